// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser.
//   state_e        : parser FSM states (encoding is visible on dbg_state)
//   OP_WR / OP_RD  : frame opcodes
//   ADDR_W_DEFAULT : PSRAM byte-address width (two address bytes on the wire)
//   sat_inc8       : 8-bit increment that sticks at 0xFF
package uart_cmd_pkg;

  localparam int ADDR_W_DEFAULT = 16;

  localparam logic [7:0] OP_WR = 8'h00;
  localparam logic [7:0] OP_RD = 8'h01;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_HI = 3'd1,
    ADDR_LO = 3'd2,
    DATA    = 3'd3,
    ISSUE   = 3'd4,
    WAIT_RD = 3'd5,
    SEND    = 3'd6
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// UART command parser: turns byte frames from a UART receiver into PSRAM
// read/write requests and returns read data to the UART transmitter.
//   write frame : 0x00, addr_hi, addr_lo, data
//   read  frame : 0x01, addr_hi, addr_lo      (read byte is echoed on tx)
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   tick_1us            : one-clk pulse per microsecond (inter-byte timeout)
//   rx_data, rx_valid   : received byte + one-clk strobe
//   req_*               : PSRAM request (valid/ready), we/addr/wdata
//   rd_valid, rd_data   : PSRAM read return
//   tx_valid/ready/data : byte to UART transmitter (valid/ready)
//   busy                : FSM not in IDLE
//   err_cnt             : saturating count of rejected bytes/frames
//   dbg_state           : current FSM state encoding (state_e)
//
// Handshake rule for req_* and tx_*: valid is driven from the state register,
// the payload is held in flops, and neither valid nor payload changes until
// the cycle in which valid && ready is sampled high at a rising clk edge.
//
// Optional feature: define UART_CMD_TIMEOUT_EN to abort partial frames when
// the gap between bytes in ADDR_HI/ADDR_LO/DATA reaches TIMEOUT_US.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int TIMEOUT_US = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1us,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [7:0]        req_wdata,
  input  logic              rd_valid,
  input  logic [7:0]        rd_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic [7:0]        err_cnt,
  output logic [2:0]        dbg_state
);

  // Only the two-byte address frame is supported.
  if (ADDR_W != 16) begin : g_addr_w_check
    $error("uart_cmd_parser: ADDR_W must be 16");
  end

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        err_q, err_d;
  logic              err_inc;
  logic              timeout;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_US < 2) ? 1 : $clog2(TIMEOUT_US + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            in_timed;

  // Counts microseconds since the last byte while a frame is half-received.
  // An arriving byte always wins over a coincident expiry.
  always_comb begin
    in_timed = (state_q == ADDR_HI) || (state_q == ADDR_LO) || (state_q == DATA);
    to_cnt_d = to_cnt_q;
    if (rx_valid || !in_timed) begin
      to_cnt_d = '0;
    end else if (tick_1us) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
    timeout = in_timed && !rx_valid && tick_1us &&
              (int'(to_cnt_q) == TIMEOUT_US - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_tick;
  assign timeout     = 1'b0;
  assign unused_tick = &{1'b0, tick_1us, (TIMEOUT_US == 0)};
`endif

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_data_d = tx_data_q;
    err_inc   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            we_d    = (rx_data == OP_WR);
            state_d = ADDR_HI;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      ADDR_HI: begin
        if (rx_valid) begin
          addr_d[15:8] = rx_data;
          state_d      = ADDR_LO;
        end else if (timeout) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end
      end
      ADDR_LO: begin
        if (rx_valid) begin
          addr_d[7:0] = rx_data;
          state_d     = we_q ? DATA : ISSUE;
        end else if (timeout) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end
      end
      DATA: begin
        if (rx_valid) begin
          wdata_d = rx_data;
          state_d = ISSUE;
        end else if (timeout) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // Bytes arriving while a command is in flight are overruns.
        if (rx_valid) err_inc = 1'b1;
        if (req_ready) state_d = we_q ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        if (rx_valid) err_inc = 1'b1;
        if (rd_valid) begin
          tx_data_d = rd_data;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (rx_valid) err_inc = 1'b1;
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_d = err_inc ? sat_inc8(err_q) : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_data_q <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
    end
  end

  assign req_valid = (state_q == ISSUE);
  assign req_we    = we_q;
  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;
  assign tx_valid  = (state_q == SEND);
  assign tx_data   = tx_data_q;
  assign busy      = (state_q != IDLE);
  assign err_cnt   = err_q;
  assign dbg_state = state_q;

endmodule
